// File: rtl/stream_reader_pkg.sv
// Shared lynx types: address/length widths, stream and opcode encodings,
// and the read request descriptor carried on the sq_rd channel.
package lynxTypes;

    localparam int VADDR_BITS  = 48;
    localparam int LEN_BITS    = 28;
    localparam int PAGE_SIZE   = 4096;
    localparam int STRM_BITS   = 2;
    localparam int PID_BITS    = 6;
    localparam int DEST_BITS   = 4;
    localparam int OPCODE_BITS = 5;

    localparam logic [STRM_BITS-1:0]   STRM_HOST  = 2'd0;
    localparam logic [OPCODE_BITS-1:0] LOCAL_READ = 5'd1;
    localparam logic [OPCODE_BITS-1:0] RDMA_READ  = 5'd8;

    typedef struct packed {
        logic [OPCODE_BITS-1:0] opcode;
        logic [STRM_BITS-1:0]   strm;
        logic                   mode;
        logic                   rdma;
        logic                   remote;
        logic [PID_BITS-1:0]    pid;
        logic [DEST_BITS-1:0]   dest;
        logic [VADDR_BITS-1:0]  vaddr;
        logic [LEN_BITS-1:0]    len;
        logic                   last;
    } req_t;

endpackage

// File: rtl/stream_reader_fifo.sv
// First-word-fall-through AXI4-Stream buffer holding tdata/tkeep beats;
// tready reflects free space and both sides are held off while in reset.
module FIFOAXI #(
    parameter int DEPTH     = 64,
    parameter int DATA_BITS = 512
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic [DATA_BITS-1:0]   s_axis_tdata,
    input  logic [DATA_BITS/8-1:0] s_axis_tkeep,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    output logic [DATA_BITS-1:0]   m_axis_tdata,
    output logic [DATA_BITS/8-1:0] m_axis_tkeep,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready
);

    localparam int KEEP_BITS = DATA_BITS / 8;
    localparam int WORD_BITS = DATA_BITS + KEEP_BITS;
    localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    logic [WORD_BITS-1:0] mem_r [DEPTH];
    logic [AW-1:0]        wr_ptr_r;
    logic [AW-1:0]        rd_ptr_r;
    logic [AW:0]          count_r;
    logic                 push_s;
    logic                 pop_s;
    logic [WORD_BITS-1:0] head_s;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] ptr);
        if (ptr == LAST_PTR) begin
            return '0;
        end else begin
            return ptr + AW'(1);
        end
    endfunction

    // Handshakes and head-of-queue view.
    always_comb begin
        s_axis_tready = !areset && (count_r != FULL_CNT);
        m_axis_tvalid = !areset && (count_r != '0);
        push_s        = s_axis_tvalid && s_axis_tready;
        pop_s         = m_axis_tvalid && m_axis_tready;
        head_s        = mem_r[rd_ptr_r];
        m_axis_tdata  = head_s[DATA_BITS-1:0];
        m_axis_tkeep  = head_s[WORD_BITS-1:DATA_BITS];
    end

    // Beat storage; contents need no reset because count_r gates visibility.
    always_ff @(posedge aclk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {s_axis_tkeep, s_axis_tdata};
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= next_ptr(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= next_ptr(rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (AW + 1)'(1);
                2'b01:   count_r <= count_r - (AW + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/stream_reader.sv
// Splits a read job into credit-limited read requests and forwards the
// returned beats, trimmed to the job length, to the consumer.
module stream_reader
    import lynxTypes::*;
#(
    parameter logic [STRM_BITS-1:0] STRM            = STRM_HOST,
    parameter int                   IS_LOCAL        = 1,
    parameter logic [DEST_BITS-1:0] DESTINATION     = '0,
    parameter int                   TRANSFER_LENGTH = 4096,
    parameter int                   FIFO_DEPTH      = 4 * (PAGE_SIZE / 64)
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [VADDR_BITS-1:0] i_vaddr,
    input  logic [LEN_BITS-1:0]   i_len,
    input  logic                  i_start_valid,
    output logic                  o_start_ready,
    output logic                  o_done,
    output logic                  sq_rd_valid,
    input  logic                  sq_rd_ready,
    output req_t                  sq_rd_data,
    input  logic [511:0]          i_data_tdata,
    input  logic [63:0]           i_data_tkeep,
    input  logic                  i_data_tvalid,
    output logic                  i_data_tready,
    output logic [511:0]          o_data_tdata,
    output logic [63:0]           o_data_tkeep,
    output logic                  o_data_tlast,
    output logic                  o_data_tvalid,
    input  logic                  o_data_tready
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam int              CW         = LEN_BITS + 1;
    localparam logic [CW-1:0]   MAX_CHUNK  = CW'(TRANSFER_LENGTH);
    localparam logic [CW:0]     CREDIT_CAP = (CW + 1)'(FIFO_DEPTH * 64);

    function automatic logic [6:0] popcount64(input logic [63:0] keep);
        logic [6:0] cnt;
        cnt = 7'd0;
        for (int i = 0; i < 64; i++) begin
            cnt = cnt + {6'd0, keep[i]};
        end
        return cnt;
    endfunction

    logic [1:0]            state_r;
    logic [VADDR_BITS-1:0] req_addr_r;
    logic [CW-1:0]         req_rem_r;
    logic [CW-1:0]         out_rem_r;
    logic [CW-1:0]         reserved_r;

    logic [CW-1:0]         chunk_s;
    logic [CW-1:0]         head_bytes_s;
    logic [CW-1:0]         res_add_s;
    logic [CW-1:0]         res_sub_s;
    logic                  credit_ok_s;
    logic                  start_fire_s;
    logic                  issue_fire_s;
    logic                  out_fire_s;
    logic [511:0]          fifo_tdata_s;
    logic [63:0]           fifo_tkeep_s;
    logic                  fifo_tvalid_s;

    // Size of the next request and whether the buffer can absorb all of it.
    always_comb begin
        if (req_rem_r > MAX_CHUNK) begin
            chunk_s = MAX_CHUNK;
        end else begin
            chunk_s = req_rem_r;
        end
        credit_ok_s = ({1'b0, reserved_r} + {1'b0, chunk_s}) <= CREDIT_CAP;
    end

    // Handshakes, framing and completion.
    always_comb begin
        o_start_ready = !areset && (state_r == ST_IDLE);
        sq_rd_valid   = !areset && (state_r == ST_ISSUE) && credit_ok_s;
        o_data_tvalid = !areset && fifo_tvalid_s && (state_r != ST_IDLE);
        o_data_tdata  = fifo_tdata_s;
        o_data_tkeep  = fifo_tkeep_s;
        head_bytes_s  = {{(CW - 7){1'b0}}, popcount64(fifo_tkeep_s)};
        o_data_tlast  = (out_rem_r == head_bytes_s);
        start_fire_s  = i_start_valid && o_start_ready;
        issue_fire_s  = sq_rd_valid && sq_rd_ready;
        out_fire_s    = o_data_tvalid && o_data_tready;
        o_done        = !areset && (state_r == ST_DRAIN) &&
                        ((out_rem_r == '0) || (out_fire_s && o_data_tlast));
        res_add_s     = issue_fire_s ? chunk_s : '0;
        res_sub_s     = out_fire_s ? head_bytes_s : '0;
    end

    // Request descriptor; fields only move on acceptance, so it holds while stalled.
    always_comb begin
        sq_rd_data        = '0;
        sq_rd_data.opcode = (IS_LOCAL != 0) ? LOCAL_READ : RDMA_READ;
        sq_rd_data.strm   = STRM;
        sq_rd_data.mode   = (IS_LOCAL == 0);
        sq_rd_data.rdma   = (IS_LOCAL == 0);
        sq_rd_data.remote = (IS_LOCAL == 0);
        sq_rd_data.pid    = '0;
        sq_rd_data.dest   = DESTINATION;
        sq_rd_data.vaddr  = req_addr_r;
        sq_rd_data.len    = chunk_s[LEN_BITS-1:0];
        sq_rd_data.last   = (req_rem_r == chunk_s);
    end

    // Job FSM with request, output and credit bookkeeping.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_r    <= ST_IDLE;
            req_addr_r <= '0;
            req_rem_r  <= '0;
            out_rem_r  <= '0;
            reserved_r <= '0;
        end else begin
            reserved_r <= reserved_r + res_add_s - res_sub_s;
            if (start_fire_s) begin
                out_rem_r <= {1'b0, i_len};
            end else if (out_fire_s) begin
                out_rem_r <= out_rem_r - head_bytes_s;
            end
            case (state_r)
                ST_IDLE: begin
                    if (start_fire_s) begin
                        req_addr_r <= i_vaddr;
                        req_rem_r  <= {1'b0, i_len};
                        state_r    <= (i_len == '0) ? ST_DRAIN : ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (issue_fire_s) begin
                        req_addr_r <= req_addr_r + VADDR_BITS'(chunk_s);
                        req_rem_r  <= req_rem_r - chunk_s;
                        if (req_rem_r == chunk_s) begin
                            state_r <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (o_done) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    FIFOAXI #(
        .DEPTH     (FIFO_DEPTH),
        .DATA_BITS (512)
    ) u_fifo (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tdata  (i_data_tdata),
        .s_axis_tkeep  (i_data_tkeep),
        .s_axis_tvalid (i_data_tvalid),
        .s_axis_tready (i_data_tready),
        .m_axis_tdata  (fifo_tdata_s),
        .m_axis_tkeep  (fifo_tkeep_s),
        .m_axis_tvalid (fifo_tvalid_s),
        .m_axis_tready (out_fire_s)
    );

endmodule

// File: tb/tb_stream_reader.sv
// Bench for stream_reader: directed scenarios plus random jobs, with a
// memory/job model that predicts requests and the consumer byte stream.
`timescale 1ns/1ps
module tb_stream_reader;
    import lynxTypes::*;

    localparam int TL    = 4096;
    localparam int DEPTH = 64;
    localparam int CAP   = DEPTH * 64;
    localparam logic [DEST_BITS-1:0] DEST = 4'd3;

    typedef struct packed {
        logic [511:0] data;
        logic [63:0]  keep;
    } beat_t;

    typedef struct packed {
        logic [VADDR_BITS-1:0] addr;
        logic [LEN_BITS-1:0]   len;
        logic                  last;
    } exp_req_t;

    logic                  aclk = 1'b0;
    logic                  areset = 1'b1;
    logic [VADDR_BITS-1:0] i_vaddr = '0;
    logic [LEN_BITS-1:0]   i_len = '0;
    logic                  i_start_valid = 1'b0;
    logic                  o_start_ready;
    logic                  o_done;
    logic                  sq_rd_valid;
    logic                  sq_rd_ready = 1'b0;
    req_t                  sq_rd_data;
    logic [511:0]          i_data_tdata = '0;
    logic [63:0]           i_data_tkeep = '0;
    logic                  i_data_tvalid = 1'b0;
    logic                  i_data_tready;
    logic [511:0]          o_data_tdata;
    logic [63:0]           o_data_tkeep;
    logic                  o_data_tlast;
    logic                  o_data_tvalid;
    logic                  o_data_tready = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    beat_t                 beat_q[$];
    exp_req_t              req_q[$];
    logic [VADDR_BITS-1:0] exp_addr;
    int exp_rem = 0, issued_bytes = 0, out_bytes = 0;
    int req_count = 0, beat_count = 0, done_count = 0, tlast_count = 0;
    int start_edge = 0, done_edge = -1;
    logic [63:0] last_keep;
    bit busy = 1'b0, in_taken = 1'b0;
    int sq_mode = 1, in_mode = 1, out_mode = 1;

    always #5 aclk = ~aclk;

    always @(posedge aclk) cyc <= cyc + 1;

    stream_reader #(
        .STRM            (STRM_HOST),
        .IS_LOCAL        (1),
        .DESTINATION     (DEST),
        .TRANSFER_LENGTH (TL),
        .FIFO_DEPTH      (DEPTH)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .i_vaddr       (i_vaddr),
        .i_len         (i_len),
        .i_start_valid (i_start_valid),
        .o_start_ready (o_start_ready),
        .o_done        (o_done),
        .sq_rd_valid   (sq_rd_valid),
        .sq_rd_ready   (sq_rd_ready),
        .sq_rd_data    (sq_rd_data),
        .i_data_tdata  (i_data_tdata),
        .i_data_tkeep  (i_data_tkeep),
        .i_data_tvalid (i_data_tvalid),
        .i_data_tready (i_data_tready),
        .o_data_tdata  (o_data_tdata),
        .o_data_tkeep  (o_data_tkeep),
        .o_data_tlast  (o_data_tlast),
        .o_data_tvalid (o_data_tvalid),
        .o_data_tready (o_data_tready)
    );

    // Host memory content: every byte is a function of its address.
    function automatic logic [7:0] byte_val(input logic [VADDR_BITS-1:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
    endfunction

    function automatic logic [63:0] keep_mask(input int n);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < n; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic bit pick(input int mode);
        if (mode == 1) return 1'b1;
        if (mode == 2) return 1'b0;
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic chk(input string tag, input logic [575:0] obs, input logic [575:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bus agent: drives readies and read data at negedge, observes handshakes just after.
    always begin
        int n;
        beat_t b;
        exp_req_t e;
        logic [511:0] exp_d, bm;
        @(negedge aclk);
        sq_rd_ready   = pick(sq_mode);
        o_data_tready = pick(out_mode);
        if (!i_data_tvalid || in_taken) begin
            if (beat_q.size() > 0 && pick(in_mode)) begin
                i_data_tvalid = 1'b1;
                i_data_tdata  = beat_q[0].data;
                i_data_tkeep  = beat_q[0].keep;
            end else begin
                i_data_tvalid = 1'b0;
            end
        end
        #1;
        in_taken = 1'b0;
        if (areset) begin
            beat_q.delete();
            req_q.delete();
            i_data_tvalid = 1'b0;
            busy = 1'b0;
        end else begin
            if (busy) chk("start_ready_busy", o_start_ready, 1'b0);
            if (i_start_valid && o_start_ready) begin
                busy = 1'b1;
                start_edge = cyc + 1;
            end
            if (sq_rd_valid && sq_rd_ready) begin
                chk("req_credit", (issued_bytes - out_bytes + int'(sq_rd_data.len)) <= CAP, 1'b1);
                if (req_q.size() == 0) begin
                    chk("req_unexpected", 1'b1, 1'b0);
                end else begin
                    e = req_q.pop_front();
                    chk("req_vaddr", sq_rd_data.vaddr, e.addr);
                    chk("req_len", sq_rd_data.len, e.len);
                    chk("req_last", sq_rd_data.last, e.last);
                    chk("req_fixed", {sq_rd_data.opcode, sq_rd_data.strm, sq_rd_data.mode, sq_rd_data.rdma,
                                      sq_rd_data.remote, sq_rd_data.pid, sq_rd_data.dest},
                        {LOCAL_READ, STRM_HOST, 3'b000, 6'd0, DEST});
                end
                issued_bytes += int'(sq_rd_data.len);
                req_count++;
                for (int off = 0; off < int'(sq_rd_data.len); off += 64) begin
                    n = (int'(sq_rd_data.len) - off > 64) ? 64 : int'(sq_rd_data.len) - off;
                    b.data = {64{8'hEE}};
                    b.keep = keep_mask(n);
                    for (int j = 0; j < n; j++) b.data[8*j +: 8] = byte_val(sq_rd_data.vaddr + VADDR_BITS'(off + j));
                    beat_q.push_back(b);
                end
            end
            if (i_data_tvalid && i_data_tready) begin
                void'(beat_q.pop_front());
                in_taken = 1'b1;
            end
            if (o_data_tvalid && o_data_tready) begin
                n = (exp_rem > 64) ? 64 : exp_rem;
                exp_d = '0;
                bm = '0;
                for (int j = 0; j < n; j++) begin
                    exp_d[8*j +: 8] = byte_val(exp_addr + VADDR_BITS'(j));
                    bm[8*j +: 8] = 8'hFF;
                end
                chk("out_keep", o_data_tkeep, keep_mask(n));
                chk("out_data", o_data_tdata & bm, exp_d);
                chk("out_last", o_data_tlast, exp_rem == n);
                exp_rem -= n;
                exp_addr += VADDR_BITS'(n);
                out_bytes += n;
                beat_count++;
                if (o_data_tlast) tlast_count++;
                last_keep = o_data_tkeep;
            end
            if (o_done) begin
                done_count++;
                done_edge = cyc;
                busy = 1'b0;
                chk("done_bytes_left", exp_rem, 0);
            end
        end
    end

    task automatic start_job(input logic [VADDR_BITS-1:0] va, input int len);
        exp_req_t e;
        @(negedge aclk);
        req_q.delete();
        for (int off = 0; off < len; off += TL) begin
            e.addr = va + VADDR_BITS'(off);
            e.len  = LEN_BITS'((len - off > TL) ? TL : len - off);
            e.last = (off + TL >= len);
            req_q.push_back(e);
        end
        exp_addr = va;
        exp_rem = len;
        issued_bytes = 0; out_bytes = 0; req_count = 0;
        beat_count = 0; done_count = 0; tlast_count = 0; done_edge = -1;
        i_vaddr = va;
        i_len = LEN_BITS'(len);
        i_start_valid = 1'b1;
        #2;
        chk("start_ready_idle", o_start_ready, 1'b1);
        @(negedge aclk);
        i_start_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (done_count == 0 && k < budget) begin
            @(negedge aclk);
            k++;
        end
        chk("done_timeout", done_count != 0, 1'b1);
        repeat (3) @(negedge aclk);
        chk("done_once", done_count, 1);
        chk("bytes_left", exp_rem, 0);
        chk("reqs_left", req_q.size(), 0);
    endtask

    task automatic check_reset_outputs();
        chk("rst_sq_valid", sq_rd_valid, 1'b0);
        chk("rst_out_valid", o_data_tvalid, 1'b0);
        chk("rst_in_ready", i_data_tready, 1'b0);
        chk("rst_done", o_done, 1'b0);
        chk("rst_start_ready", o_start_ready, 1'b0);
    endtask

    initial begin
        int len, k;
        logic [VADDR_BITS-1:0] va;

        repeat (3) @(negedge aclk);
        #2;
        check_reset_outputs();
        @(negedge aclk);
        areset = 1'b0;
        #2;
        chk("idle_start_ready", o_start_ready, 1'b1);
        chk("idle_sq_valid", sq_rd_valid, 1'b0);
        chk("idle_out_valid", o_data_tvalid, 1'b0);
        chk("idle_done", o_done, 1'b0);

        // Two full transfers.
        start_job(48'h1000, 8192);
        wait_done(3000);
        chk("s8k_reqs", req_count, 2);
        chk("s8k_beats", beat_count, 128);
        chk("s8k_tlast", tlast_count, 1);

        // Partial final beat.
        start_job(48'h20000, 4100);
        wait_done(3000);
        chk("s4100_reqs", req_count, 2);
        chk("s4100_keep", last_keep, 64'hF);
        chk("s4100_bytes", out_bytes, 4100);

        // Zero-length job.
        start_job(48'h3000, 0);
        wait_done(50);
        chk("zero_latency", done_edge, start_edge);
        chk("zero_reqs", req_count, 0);
        chk("zero_beats", beat_count, 0);

        // Consumer stalled: only one transfer fits the buffer.
        out_mode = 2;
        start_job(48'h40000, 16384);
        repeat (300) @(negedge aclk);
        chk("bp_one_req", req_count, 1);
        chk("bp_no_out", beat_count, 0);
        out_mode = 1;
        wait_done(5000);
        chk("bp_reqs", req_count, 4);

        // Random jobs under random back-pressure on every channel.
        sq_mode = 0; in_mode = 0; out_mode = 0;
        for (int j = 0; j < 20; j++) begin
            len = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 12000));
            va = {16'h0, $urandom()};
            start_job(va, len);
            wait_done(10000);
        end

        // Reset in the middle of draining a job, then a fresh small job.
        start_job(48'h50000, 4096);
        k = 0;
        while (out_bytes < 1024 && k < 3000) begin
            @(negedge aclk);
            k++;
        end
        chk("rst_progress", out_bytes >= 1024, 1'b1);
        @(negedge aclk);
        areset = 1'b1;
        @(negedge aclk);
        #2;
        check_reset_outputs();
        @(negedge aclk);
        areset = 1'b0;
        start_job(48'h60040, 64);
        wait_done(500);
        chk("post_rst_beats", beat_count, 1);
        chk("post_rst_keep", last_keep, {64{1'b1}});

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_reader.md
STREAM_READER -- requirements
Module: stream_reader

Interface
REQ-001 Parameter STRM, default STRM_HOST, target stream of every read request.
REQ-002 Parameter IS_LOCAL, default 1, 1 selects LOCAL_READ and 0 selects RDMA_READ.
REQ-003 Parameter DESTINATION, default 0, dest field of every request.
REQ-004 Parameter TRANSFER_LENGTH, default 4096, maximum bytes per request, a multiple of 64.
REQ-005 Parameter FIFO_DEPTH, default 4*(PAGE_SIZE/64), data buffer depth in 64-byte beats, at least TRANSFER_LENGTH/64.
REQ-006 Ports:
- aclk  in  1  clock; one clock; all logic on its rising edge.
- areset  in  1  reset; synchronous, active-high.
- i_vaddr  in  VADDR_BITS  job start address, sampled on start handshake.
- i_len  in  LEN_BITS  job total bytes, sampled on start handshake.
- i_start_valid  in  1  job request.
- o_start_ready  out  1  high only in IDLE.
- o_done  out  1  one-cycle pulse after the last job byte leaves o_data.
- sq_rd  metaIntf.m  req_t  read request channel.
- i_data  AXI4S.s  512  returned read data.
- o_data  AXI4S.m  512  job data to the consumer.

Function
REQ-007 FSM states: IDLE, ISSUE, DRAIN; reset state IDLE.
REQ-008 IDLE->ISSUE on i_start_valid&&o_start_ready; latch i_vaddr into req_addr and i_len into req_rem and out_rem.
REQ-009 Zero-length job: IDLE->DRAIN with no request; o_done pulses the following cycle.
REQ-010 In ISSUE, chunk = min(req_rem, TRANSFER_LENGTH).
REQ-011 sq_rd.valid asserts in ISSUE only when reserved+chunk <= FIFO_DEPTH*64.
REQ-012 sq_rd.data fields: opcode per IS_LOCAL; strm=STRM; mode, rdma and remote = ~IS_LOCAL; pid=0; dest=DESTINATION; vaddr=req_addr; len=chunk; last=(req_rem==chunk).
REQ-013 On sq_rd.valid&&sq_rd.ready: req_addr+=chunk, req_rem-=chunk, reserved+=chunk; if req_rem becomes 0, ISSUE->DRAIN.
REQ-014 sq_rd.data is stable while sq_rd.valid is high and not accepted.
REQ-015 i_data feeds the FIFO directly; i_data.tready = FIFO not full; data is accepted in any state.
REQ-016 o_data tdata/tkeep come from the FIFO head; o_data.tvalid = FIFO valid && state!=IDLE.
REQ-017 o_data.tlast = (out_rem == popcount(tkeep)) on the head beat.
REQ-018 On each o_data handshake: out_rem -= popcount(tkeep) and reserved -= popcount(tkeep).
REQ-019 When request issue and output drain occur in the same cycle, reserved is updated by the net sum of both.
REQ-020 DRAIN->IDLE on the handshake with tlast; o_done pulses in that same cycle.
REQ-021 Byte counters are LEN_BITS+1 wide and never wrap; address arithmetic is modulo 2^VADDR_BITS.
REQ-022 The final chunk may be a partial beat; the consumer sees exactly i_len bytes.
REQ-023 A start request while not in IDLE is ignored (o_start_ready=0).

Reset
REQ-024 On areset=1: state IDLE, FIFO flushed, and req_addr, req_rem, out_rem and reserved all cleared.
REQ-025 Output values during reset: sq_rd.valid=0, o_data.tvalid=0, i_data.tready=0, o_done=0, o_start_ready=0.
REQ-026 Reset mid-job abandons the job; read data still in flight after reset is not part of any job.

Structure
REQ-027 req_t, VADDR_BITS, LEN_BITS, PAGE_SIZE, STRM_HOST, LOCAL_READ and RDMA_READ come from the shared lynxTypes package; no new package types are added.
REQ-028 There is exactly one sub-module: the existing FIFOAXI, depth FIFO_DEPTH, used as the data buffer.
REQ-029 The credit check (reserved) guarantees that no issued read can stall i_data indefinitely.

Verification
REQ-030 Scenario: i_len=8192, vaddr=0x1000, TRANSFER_LENGTH 4096 -> two requests (0x1000/4096/last=0, 0x2000/4096/last=1); 128 beats out; tlast on beat 128; one o_done.
REQ-031 Scenario: i_len=4100 -> requests of 4096 and 4 bytes; final beat has tkeep=0xF with tlast; out total 4100 bytes.
REQ-032 Scenario: i_len=0 -> no sq_rd.valid, no o_data beats; o_done exactly 1 cycle after start.
REQ-033 Scenario: FIFO_DEPTH=64, i_len=16384, o_data.tready held low -> exactly one request issued; the second issues only after 64 beats drain.
REQ-034 Scenario: random sq_rd.ready and o_data.tready, 20 jobs of random length -> byte-exact data, one o_done per job, o_start_ready low while busy.
REQ-035 Scenario: areset asserted mid-DRAIN of a 4096-byte job -> next cycle all outputs at reset values; a new 64-byte job then completes correctly.
